mdu_div: RTL and testbench
==========================

// Module: mdu_div
// PURPOSE
//  Multi-cycle 32/32 radix-2 restoring divider serving the issue-slot-1 EX unit.
//  Responder side of the EX div handshake: EX drives operands/start/sign; block returns
//  {remainder, quotient} and ready. Feeds HI/LO writeback via EX (HI=remainder, LO=quotient).
// PARAMETERS
//  (none; width fixed at 32 by the ISA)
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, synchronous, active-high
//  signed_div_i  in   1   1 = DIV (two's complement), 0 = DIVU
//  opdata1_i     in   32  dividend
//  opdata2_i     in   32  divisor
//  start_i       in   1   request; EX holds high until it sees ready_o
//  annul_i       in   1   abort current op (live only with DIV_ANNUL_EN)
//  result_o      out  64  {remainder[63:32], quotient[31:0]}, valid while ready_o=1
//  ready_o       out  1   result valid
// BEHAVIOUR
//  - All outputs registered. Reset: state=FREE, cnt=0, ready_o=0, result_o=64'h0.
//  - FSM states FREE, BY_ZERO, ON, END.
//  - FREE: start_i=1 (and annul_i=0 under DIV_ANNUL_EN) samples operands and sign mode.
//    opdata2_i==0 -> BY_ZERO; else -> ON, cnt=0, load |dividend|, |divisor| (abs only if
//    signed_div_i=1), latch neg_q = sign1^sign2, neg_r = sign1 (signed mode only).
//  - BY_ZERO: next edge -> END, result_o=64'h0, ready_o=1. Latency 2 edges from start edge.
//  - ON: one restoring step per cycle on 65-bit partial remainder: trial = rem_hi - divisor;
//    if no borrow, rem_hi=trial, shift in q bit 1, else shift in 0. cnt increments 0..32.
//    Edge with cnt==32: apply sign correction (quotient negated if neg_q, remainder
//    negated if neg_r), write result_o, ready_o=1, -> END.
//    Latency: ready_o visible after the 34th edge counting the start-sampling edge as 1.
//  - END: ready_o=1 and result_o held stable while start_i=1. start_i=0 -> FREE next edge,
//    ready_o=0, result_o=64'h0.
//  - Operand inputs and start_i are ignored outside FREE (no restart, no re-sample).
//  - Arithmetic: abs/negation modulo 2^32. -2^31 / -1 signed -> quotient 32'h80000000,
//    remainder 0 (no trap; overflow is unpredictable in the ISA, this is the defined value).
//  - Unsigned mode never negates; sign bits treated as magnitude.
//  - rst mid-operation (any state) returns to reset values on that edge; in-flight op lost.
//  - Simultaneous rst and start_i: rst wins, start not sampled.
// CONFIGURATION
//  DIV_ANNUL_EN defined: annul_i=1 in ON or BY_ZERO -> FREE next edge, ready_o stays 0,
//    result_o unchanged (0); annul_i=1 in FREE blocks start acceptance; annul_i in END
//    ignored (result already committed, EX releases via start_i=0).
//  DIV_ANNUL_EN undefined: annul_i ignored everywhere; every accepted op runs to END.
// TESTING
//  - DIVU 100/7, start held -> ready_o=1 after edge 34, result_o={32'd2,32'd14}.
//  - DIV -7/2 -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF; DIV 7/-2 -> q 32'hFFFFFFFD, r 1.
//  - DIV 32'h80000000/32'hFFFFFFFF -> result_o={32'h0,32'h80000000}; DIVU same -> q 0, r 32'h80000000.
//  - Divisor 0 (either mode) -> ready_o=1 after edge 2, result_o=64'h0.
//  - Hold start_i 5 cycles in END -> result stable, ready_o=1; drop start_i -> ready_o=0,
//    result_o=0 next edge; new start next cycle accepted normally.
//  - rst pulse at cycle 10 of DIVU 1000/3 -> ready_o=0 next edge; new 9/4 yields {1,2};
//    with DIV_ANNUL_EN, annul_i at cycle 10 -> FREE, ready_o never rises for that op.

Source files
------------

// File: rtl/mdu_div.sv
// mdu_div: 32/32 radix-2 restoring divider for the slot-1 EX unit.
// Optional abort path enabled by defining DIV_ANNUL_EN.
module mdu_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic [1:0] FREE    = 2'd0;
  localparam logic [1:0] BY_ZERO = 2'd1;
  localparam logic [1:0] ON      = 2'd2;
  localparam logic [1:0] END     = 2'd3;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [63:0] rem;
  logic [31:0] dsr;
  logic        neg_q;
  logic        neg_r;

  logic        annul;
  logic        sign1;
  logic        sign2;
  logic [31:0] dvd_abs;
  logic [31:0] dsr_abs;
  logic [32:0] part_hi;
  logic        no_borrow;
  logic [31:0] trial;
  logic [63:0] rem_step;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

`ifdef DIV_ANNUL_EN
  assign annul = annul_i;
`else
  logic unused_annul;
  assign unused_annul = annul_i;
  assign annul = 1'b0;
`endif

  // operand magnitudes; sign bits only matter in signed mode
  always_comb begin
    sign1   = signed_div_i & opdata1_i[31];
    sign2   = signed_div_i & opdata2_i[31];
    dvd_abs = sign1 ? (32'h0 - opdata1_i) : opdata1_i;
    dsr_abs = sign2 ? (32'h0 - opdata2_i) : opdata2_i;
  end

  // one restoring step: shift, trial-subtract, keep if no borrow
  always_comb begin
    part_hi   = rem[63:31];
    no_borrow = (part_hi >= {1'b0, dsr});
    trial     = rem[62:31] - dsr;
    if (no_borrow)
      rem_step = {trial, rem[30:0], 1'b1};
    else
      rem_step = {rem[62:0], 1'b0};
  end

  // sign correction applied to the finished magnitudes
  always_comb begin
    q_fix = neg_q ? (32'h0 - rem[31:0])  : rem[31:0];
    r_fix = neg_r ? (32'h0 - rem[63:32]) : rem[63:32];
  end

  // control FSM, datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      rem      <= 64'h0;
      dsr      <= 32'h0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= 64'h0;
    end else begin
      unique case (state)
        FREE: begin
          if (start_i && !annul) begin
            if (opdata2_i == 32'h0) begin
              state <= BY_ZERO;
            end else begin
              state <= ON;
              cnt   <= 6'd0;
              rem   <= {32'h0, dvd_abs};
              dsr   <= dsr_abs;
              neg_q <= sign1 ^ sign2;
              neg_r <= sign1;
            end
          end
        end
        BY_ZERO: begin
          if (annul) begin
            state <= FREE;
          end else begin
            state    <= END;
            result_o <= 64'h0;
            ready_o  <= 1'b1;
          end
        end
        ON: begin
          if (annul) begin
            state <= FREE;
          end else if (cnt == 6'd32) begin
            state    <= END;
            result_o <= {r_fix, q_fix};
            ready_o  <= 1'b1;
          end else begin
            rem <= rem_step;
            cnt <= cnt + 6'd1;
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= 64'h0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div.sv
// tb_mdu_div: vector table plus scoreboard bench for mdu_div.
// Define DIV_ANNUL_EN to also exercise the abort path.
module tb_mdu_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  vec_t vecs [10];
  exp_t scb [$];

  mdu_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] res,
                        input int hold);
    exp_t e;
    int   n;
    e.res = res;
    e.lat = (b == 32'h0) ? 2 : 34;
    scb.push_back(e);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
    end while (!ready_o && n < 60);
    e = scb.pop_front();
    chk("latency", 64'(n), 64'(e.lat));
    chk("result", result_o, e.res);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_ready", {63'h0, ready_o}, 64'h1);
      chk("hold_result", result_o, e.res);
    end
    start_i = 1'b0;
    tick();
    chk("drop_ready", {63'h0, ready_o}, 64'h0);
    chk("drop_result", result_o, 64'h0);
  endtask

  initial begin
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          seen;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h0};
    vecs[4] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'h0,        32'h80000000};
    vecs[5] = '{1'b0, 32'd1234,       32'h0,        32'h0,        32'h0};
    vecs[6] = '{1'b1, 32'hFFFFFFF9,   32'h0,        32'h0,        32'h0};
    vecs[7] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'h0};
    vecs[8] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
    vecs[9] = '{1'b0, 32'd5,          32'd9,        32'd0,        32'd5};

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h0;
    opdata2_i    = 32'h0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    chk("rst_ready", {63'h0, ready_o}, 64'h0);
    chk("rst_result", result_o, 64'h0);

    // rst and start together: start must not be sampled
    opdata1_i = 32'd5;
    opdata2_i = 32'h0;
    start_i   = 1'b1;
    tick();
    rst     = 1'b0;
    start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ready_o) seen++;
    end
    chk("rst_start_ignored", 64'(seen), 64'h0);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b,
             {vecs[i].r, vecs[i].q}, (i == 0) ? 5 : 1);

    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 28);
      if (b == 32'h0) b = 32'd3;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
      if (s) begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end else begin
        q = a / b;
        r = a % b;
      end
      run_op(s, a, b, {r, q}, 0);
    end

    // reset mid-operation
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (10) tick();
    rst     = 1'b1;
    start_i = 1'b0;
    tick();
    chk("midrst_ready", {63'h0, ready_o}, 64'h0);
    chk("midrst_result", result_o, 64'h0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) seen++;
    end
    chk("midrst_no_ready", 64'(seen), 64'h0);
    run_op(1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 0);

`ifdef DIV_ANNUL_EN
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (10) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready_o) seen++;
    end
    chk("annul_on", 64'(seen), 64'h0);
    chk("annul_result", result_o, 64'h0);

    opdata2_i = 32'h0;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready_o) seen++;
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    chk("annul_free_block", 64'(seen), 64'h0);
    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
